// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited pipelined imem reads,
// and queues returned words with their PCs for decode, discarding wrong-path responses.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] instr_pc_plus4
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]           DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));
    localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         fifo_count_q, fifo_count_d;
    logic [PW-1:0]         fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PW-1:0]         tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tag_pc_q    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tag_pc_d    [FIFO_DEPTH];

    logic accept;
    logic pop;
    logic push;
    logic head_valid;

    // In-flight requests plus buffered words never exceed the FIFO, so responses need no backpressure.
    assign imem_req_valid = !rst && (({1'b0, outstanding_q} + {1'b0, fifo_count_q}) < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q & ALIGN_MASK;
    assign accept         = imem_req_valid && imem_req_ready;

    assign head_valid     = (fifo_count_q != '0);
    assign instr_valid    = head_valid && !PCSrc;
    assign pop            = instr_valid && instr_ready;
    assign instr          = head_valid ? fifo_data_q[fifo_rd_q] : '0;
    assign instr_pc       = head_valid ? fifo_pc_q[fifo_rd_q] : '0;
    assign instr_pc_plus4 = head_valid ? (fifo_pc_q[fifo_rd_q] + WORD_BYTES) : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_d        = drop_q;
        fifo_count_d  = fifo_count_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        fifo_data_d   = fifo_data_q;
        fifo_pc_d     = fifo_pc_q;
        tag_pc_d      = tag_pc_q;
        push          = 1'b0;

        if (PCSrc) begin
            // Everything still in flight after this edge, including a request accepted now, is wrong-path.
            fetch_pc_d   = PCTarget & ALIGN_MASK;
            drop_d       = outstanding_d;
            fifo_count_d = '0;
            fifo_wr_d    = '0;
            fifo_rd_d    = '0;
            tag_wr_d     = '0;
            tag_rd_d     = '0;
        end else begin
            if (accept) begin
                fetch_pc_d         = fetch_pc_q + WORD_BYTES;
                tag_pc_d[tag_wr_q] = imem_req_addr;
                tag_wr_d           = tag_wr_q + PW'(1);
            end
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push                   = 1'b1;
                    fifo_data_d[fifo_wr_q] = imem_rsp_data;
                    fifo_pc_d[fifo_wr_q]   = tag_pc_q[tag_rd_q];
                    fifo_wr_d              = fifo_wr_q + PW'(1);
                    tag_rd_d               = tag_rd_q + PW'(1);
                end
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + PW'(1);
            end
            fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            fifo_count_q  <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                tag_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fifo_count_q  <= fifo_count_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fifo_data_q   <= fifo_data_d;
            fifo_pc_q     <= fifo_pc_d;
            tag_pc_q      <= tag_pc_d;
        end
    end

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0));

endmodule
